write_burst_len_ctrl: RTL
=========================

// Module: write_burst_len_ctrl
// PURPOSE
// Write-side burst scheduler for the VDMA frame-store path. Counts the AXI words of a frame (MODE "ONCE")
// or of each line (MODE "LINE"), and issues NOR_BURST_LEN bursts followed by one short tail burst.
// Each burst is requested only once the write FIFO holds enough words for it.
// Sits between the video-in write FIFO and the AXI AW/W issuer; it mirrors the tail-length logic on the read side.
// PARAMETERS
// NOR_BURST_LEN  200     normal burst length in AXI beats (1..2**LSIZE-1)
// MODE           "ONCE"  "ONCE": whole frame is one segment; "LINE": each line is one segment
// AXI_DSIZE      256     AXI data width, bits (power of 2)
// DSIZE          24      pixel width, bits
// LSIZE          9       width of burst_len
// PORTS
// clock        in   1      single clock domain
// rst_n        in   1      asynchronous, active-low reset
// vactive      in   16     lines per frame, sampled on fsync
// hactive      in   16     pixels per line, sampled on fsync
// fsync        in   1      one-cycle frame start pulse
// fifo_count   in   16     words currently held in the write FIFO
// burst_req    out  1      burst request, held high until burst_ack
// burst_len    out  LSIZE  beats in the requested burst (not minus one), stable while burst_req is high
// burst_ack    in   1      issuer accepted the request
// burst_done   in   1      last W beat of the accepted burst has been sent
// tail_flag    out  1      current request is the short tail of its segment
// frame_done   out  1      one-cycle pulse after the final burst_done of the frame
// BEHAVIOUR
// Reset state: IDLE. Outputs: burst_req=0, burst_len=0, tail_flag=0, frame_done=0. Counters: 0.
// Arithmetic on fsync:
// - seg_pix = (MODE=="LINE") ? hactive : vactive*hactive, 32 bits.
// - seg_words = ceil(seg_pix*DSIZE / AXI_DSIZE): 40-bit intermediate, round up by testing the low log2(AXI_DSIZE) bits, 32-bit result.
// - lines_left = (MODE=="LINE") ? vactive : 1.
// FSM states: IDLE, CALC, WAIT_DATA, REQ, WAIT_DONE, DONE.
// - IDLE: on fsync -> CALC, which latches vactive/hactive.
// - CALC: computes seg_words and loads remaining = seg_words -> WAIT_DATA at fsync+2.
// - CALC, zero case: if seg_words==0 or lines_left==0 -> DONE instead, and no burst is issued.
// - WAIT_DATA, normal burst: if remaining>=NOR_BURST_LEN and fifo_count>=NOR_BURST_LEN
//   -> REQ with len=NOR_BURST_LEN, tail=0.
// - WAIT_DATA, tail burst: elif 0<remaining<NOR_BURST_LEN and fifo_count>=remaining -> REQ with len=remaining, tail=1.
// - REQ: burst_req=1 and burst_len/tail_flag registered, all stable until burst_ack.
//   On burst_ack: burst_req drops the next cycle -> WAIT_DONE.
// - WAIT_DONE: on burst_done, remaining -= burst_len.
//   - If remaining becomes 0: lines_left -= 1. If lines_left is then 0 -> DONE; else reload remaining=seg_words -> WAIT_DATA.
//   - Otherwise -> WAIT_DATA.
// - DONE: frame_done=1 for exactly one cycle -> IDLE.
// Handshake rules:
// - burst_done is counted only in WAIT_DONE; the issuer guarantees it comes at least 1 cycle after burst_ack.
// - burst_ack outside REQ is ignored.
// fsync in any non-IDLE state aborts the frame:
// - burst_req drops, and an outstanding burst_done is discarded.
// - The FSM re-enters CALC with the new vactive/hactive. frame_done is not pulsed for the aborted frame.
// fifo_count is compared unsigned; a FIFO shortfall simply holds WAIT_DATA, with no timeout.
// Reset asserted mid-burst: immediate return to the reset state, outputs as at reset.
// TESTING
// ONCE, h=1920 v=1080: seg_words=194400 -> 972 bursts of 200, tail_flag always 0, one frame_done.
// LINE, h=4000 v=2: 375 words/line -> per line a 200 burst then a 175 burst with tail_flag=1; 4 bursts in total, frame_done after the 4th burst_done.
// ONCE, h=100 v=3: 7200 bits -> 29 words (round-up) -> single burst_len=29, tail_flag=1.
// Hold fifo_count=150 with 200 needed: burst_req stays 0. Raise fifo_count to 200 -> burst_req=1 the next cycle. Delay burst_ack 5 cycles -> len stable.
// fsync during WAIT_DONE, then a stale burst_done: the stale done is ignored, remaining reloads, no frame_done.
// h=0: frame_done pulses at fsync+2 with no burst_req. Reset mid-REQ: burst_req=0 immediately.

Source files
------------

// File: rtl/write_burst_len_ctrl.sv
// write_burst_len_ctrl
//   Write-side burst scheduler for the VDMA frame-store path. On fsync it
//   sizes the segment (whole frame, or one line in LINE mode) in AXI words.
//   It then requests NOR_BURST_LEN-beat bursts, plus one short tail burst per
//   segment. A burst is only requested once the write FIFO holds enough words.
// Ports
//   clock, rst_n          single clock, async active-low reset
//   vactive, hactive      frame geometry, captured on fsync
//   fsync                 frame start pulse; also aborts a frame in progress
//   fifo_count            words currently in the write FIFO
//   burst_req/ack         request handshake, burst_req held until burst_ack
//   burst_len, tail_flag  beats in the request (not minus one) / tail marker
//   burst_done            last W beat of the accepted burst was sent
//   frame_done            one-cycle pulse after the last burst of the frame
module write_burst_len_ctrl #(
  parameter int NOR_BURST_LEN = 200,
  parameter     MODE          = "ONCE",
  parameter int AXI_DSIZE     = 256,
  parameter int DSIZE         = 24,
  parameter int LSIZE         = 9
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [15:0]      vactive,
  input  logic [15:0]      hactive,
  input  logic             fsync,
  input  logic [15:0]      fifo_count,
  output logic             burst_req,
  output logic [LSIZE-1:0] burst_len,
  input  logic             burst_ack,
  input  logic             burst_done,
  output logic             tail_flag,
  output logic             frame_done
);

  localparam bit LINE_MODE = (MODE == "LINE");
  localparam int ASH       = $clog2(AXI_DSIZE);
  localparam logic [31:0] NOR = 32'(NOR_BURST_LEN);

  typedef enum logic [2:0] {IDLE, CALC, WAIT_DATA, REQ, WAIT_DONE, DONE} state_t;

  state_t           state_q, state_d;
  logic [15:0]      v_q, v_d, h_q, h_d;
  logic [15:0]      lines_q, lines_d;
  logic [31:0]      seg_words_q, seg_words_d;
  logic [31:0]      remaining_q, remaining_d;
  logic [LSIZE-1:0] len_q, len_d;
  logic             tail_q, tail_d;

  logic [31:0] seg_pix, seg_words, fifo32, rem_after;
  logic [39:0] seg_bits;
  logic        nor_fit, tail_fit;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      v_q         <= '0;
      h_q         <= '0;
      lines_q     <= '0;
      seg_words_q <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      tail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      h_q         <= h_d;
      lines_q     <= lines_d;
      seg_words_q <= seg_words_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      tail_q      <= tail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    h_d         = h_q;
    lines_d     = lines_q;
    seg_words_d = seg_words_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    tail_d      = tail_q;

    seg_pix   = LINE_MODE ? {16'd0, h_q} : 32'(v_q) * 32'(h_q);
    seg_bits  = 40'(seg_pix) * 40'(DSIZE);
    // ceil divide by the AXI word width: any leftover bit costs one more word
    seg_words = 32'(seg_bits >> ASH) + {31'd0, |seg_bits[ASH-1:0]};
    fifo32    = {16'd0, fifo_count};
    nor_fit   = (remaining_q >= NOR) && (fifo32 >= NOR);
    tail_fit  = (remaining_q != 32'd0) && (remaining_q < NOR) && (fifo32 >= remaining_q);
    rem_after = remaining_q - 32'(len_q);

    if (fsync) begin
      // fsync always restarts; an in-flight burst_done is never counted
      // because the FSM leaves WAIT_DONE here
      state_d = CALC;
      v_d     = vactive;
      h_d     = hactive;
    end else begin
      case (state_q)
        IDLE: ;
        CALC: begin
          seg_words_d = seg_words;
          remaining_d = seg_words;
          lines_d     = LINE_MODE ? v_q : 16'd1;
          if (seg_words == 32'd0 || lines_d == 16'd0) state_d = DONE;
          else                                        state_d = WAIT_DATA;
        end
        WAIT_DATA: begin
          if (nor_fit) begin
            len_d   = LSIZE'(NOR_BURST_LEN);
            tail_d  = 1'b0;
            state_d = REQ;
          end else if (tail_fit) begin
            len_d   = LSIZE'(remaining_q);
            tail_d  = 1'b1;
            state_d = REQ;
          end
        end
        REQ: if (burst_ack) state_d = WAIT_DONE;
        WAIT_DONE: begin
          if (burst_done) begin
            remaining_d = rem_after;
            state_d     = WAIT_DATA;
            if (rem_after == 32'd0) begin
              lines_d = lines_q - 16'd1;
              if (lines_q == 16'd1) state_d = DONE;
              else                  remaining_d = seg_words_q;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // request and pulse are pure state decodes so reset clears them at once
  assign burst_req  = (state_q == REQ);
  assign frame_done = (state_q == DONE);
  assign burst_len  = len_q;
  assign tail_flag  = tail_q;

endmodule
